gather_packetizer: RTL and testbench

- Local injection stage directly upstream of the gather router's local input stage.
- Takes a raw payload stream from the PE/accumulator (valid/ready, with an optional end-of-stream marker).
- Frames the stream into gather packets: one head flit carrying the stream ID, then payload flits, the last one marked tail.
- Presents the flits through a registered valid/ready output into the gather input FIFO.

---
 rtl/gather_packetizer.sv | 111 +++++++++++
 tb/tb_gather_packetizer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gather_packetizer.sv
// Gather packetizer: frames a raw payload stream into head/body/tail flits
// and presents them through a one-deep registered valid/ready output.
`ifndef DW
`define DW 32
`endif
`ifndef STREAM_ID_H
`define STREAM_ID_H 7
`endif
`ifndef STREAM_ID_L
`define STREAM_ID_L 0
`endif

module gather_packetizer #(
    parameter int unsigned stream_id = 0,
    parameter int unsigned pl        = 16,
    parameter int unsigned cnt_w     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pld_valid_i,
    input  logic [`DW-3:0]   pld_data_i,
    input  logic             pld_last_i,
    output logic             pld_ready_o,
    output logic             valid_o,
    output logic [`DW-1:0]   data_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic [cnt_w-1:0] pkt_cnt_o
);

    localparam int SID_W = `STREAM_ID_H - `STREAM_ID_L + 1;
    localparam logic [SID_W-1:0] SID      = SID_W'(stream_id);
    localparam logic [cnt_w-1:0] LAST_CNT = cnt_w'(pl - 1);
    localparam logic [1:0] TYP_HEAD = 2'b10;
    localparam logic [1:0] TYP_BODY = 2'b00;
    localparam logic [1:0] TYP_TAIL = 2'b01;

    typedef enum logic {HEAD, PAYLOAD} state_t;

    state_t           state, state_n;
    logic [cnt_w-1:0] flit_cnt, flit_cnt_n;
    logic             ld;
    logic             load;
    logic             is_tail;
    logic [`DW-1:0]   flit_n;

    assign ld      = ~valid_o | ready_i;
    assign is_tail = (flit_cnt == LAST_CNT) | pld_last_i;
    assign busy_o  = (state == PAYLOAD);

    always_comb begin
        state_n     = state;
        flit_cnt_n  = flit_cnt;
        load        = 1'b0;
        flit_n      = '0;
        pld_ready_o = 1'b0;
        unique case (state)
            HEAD: begin
                // Head goes out ahead of the beat; the beat waits a cycle.
                if (pld_valid_i && ld) begin
                    load                             = 1'b1;
                    flit_n[`DW-1:`DW-2]              = TYP_HEAD;
                    flit_n[`STREAM_ID_H:`STREAM_ID_L] = SID;
                    flit_cnt_n                       = cnt_w'(1);
                    state_n                          = PAYLOAD;
                end
            end
            PAYLOAD: begin
                pld_ready_o = ld;
                if (pld_valid_i && ld) begin
                    load          = 1'b1;
                    flit_n        = {is_tail ? TYP_TAIL : TYP_BODY,
                                     pld_data_i};
                    if (is_tail) begin
                        flit_cnt_n = '0;
                        state_n    = HEAD;
                    end else begin
                        flit_cnt_n = flit_cnt + cnt_w'(1);
                    end
                end
            end
            default: state_n = HEAD;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= HEAD;
            flit_cnt <= '0;
        end else begin
            state    <= state_n;
            flit_cnt <= flit_cnt_n;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_o   <= 1'b0;
            data_o    <= '0;
            pkt_cnt_o <= '0;
        end else begin
            if (ld) begin
                valid_o <= load;
                if (load) data_o <= flit_n;
            end
            if (valid_o && ready_i && data_o[`DW-1:`DW-2] == TYP_TAIL)
                pkt_cnt_o <= pkt_cnt_o + cnt_w'(1);
        end
    end

endmodule

// File: tb/tb_gather_packetizer.sv
// Directed bench for gather_packetizer: three instances (pl=4, pl=16,
// pl=2 with a 2-bit packet counter) checked against a framing model.
`ifndef DW
`define DW 32
`endif
`ifndef STREAM_ID_H
`define STREAM_ID_H 7
`endif
`ifndef STREAM_ID_L
`define STREAM_ID_L 0
`endif

module tb_gather_packetizer;

    localparam int DW = `DW;
    localparam int PW = DW - 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn  [3];
    logic          pv    [3];
    logic [PW-1:0] pd    [3];
    logic          plast [3];
    logic          pr    [3];
    logic          vo    [3];
    logic [DW-1:0] dout  [3];
    logic          rdy   [3];
    logic          busy  [3];
    logic [15:0]   pca, pcb;
    logic [1:0]    pcc;
    logic [15:0]   pc    [3];

    assign pc[0] = pca;
    assign pc[1] = pcb;
    assign pc[2] = {14'd0, pcc};

    gather_packetizer #(.stream_id(5), .pl(4), .cnt_w(16)) u_a (
        .clk(clk), .rstn(rstn[0]), .pld_valid_i(pv[0]),
        .pld_data_i(pd[0]), .pld_last_i(plast[0]),
        .pld_ready_o(pr[0]), .valid_o(vo[0]), .data_o(dout[0]),
        .ready_i(rdy[0]), .busy_o(busy[0]), .pkt_cnt_o(pca));

    gather_packetizer #(.stream_id(9), .pl(16), .cnt_w(16)) u_b (
        .clk(clk), .rstn(rstn[1]), .pld_valid_i(pv[1]),
        .pld_data_i(pd[1]), .pld_last_i(plast[1]),
        .pld_ready_o(pr[1]), .valid_o(vo[1]), .data_o(dout[1]),
        .ready_i(rdy[1]), .busy_o(busy[1]), .pkt_cnt_o(pcb));

    gather_packetizer #(.stream_id(3), .pl(2), .cnt_w(2)) u_c (
        .clk(clk), .rstn(rstn[2]), .pld_valid_i(pv[2]),
        .pld_data_i(pd[2]), .pld_last_i(plast[2]),
        .pld_ready_o(pr[2]), .valid_o(vo[2]), .data_o(dout[2]),
        .ready_i(rdy[2]), .busy_o(busy[2]), .pkt_cnt_o(pcc));

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    // Monitor-owned, append-only records
    logic [DW-1:0] gotq [3][$];
    int            fcyc [3][$];
    logic [15:0]   pcq  [3][$];
    logic [15:0]   last_pc [3];
    logic          hold_v  [3];
    logic [DW-1:0] hold_d  [3];
    int            unstable [3];

    // Bench-owned model state
    logic [DW-1:0] expq [3][$];
    int gb [3];
    int eb [3];
    int pb [3];
    int inpkt [3];
    int mcnt  [3];
    bit rmode;

    initial begin
        for (int k = 0; k < 3; k++) begin
            last_pc[k]  = '0;
            hold_v[k]   = 1'b0;
            hold_d[k]   = '0;
            unstable[k] = 0;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (vo[k] && rdy[k]) begin
                gotq[k].push_back(dout[k]);
                fcyc[k].push_back(cyc);
            end
            if (hold_v[k] && rstn[k] && (!vo[k] || dout[k] !== hold_d[k]))
                unstable[k] <= unstable[k] + 1;
            hold_v[k] <= vo[k] && !rdy[k] && rstn[k];
            hold_d[k] <= dout[k];
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (pc[k] !== last_pc[k]) begin
                pcq[k].push_back(pc[k]);
                last_pc[k] <= pc[k];
            end
        end
    end

    function automatic int pl_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 16 : 2;
    endfunction

    function automatic logic [DW-1:0] head_of(input int k);
        logic [DW-1:0] f;
        int s;
        s = (k == 0) ? 5 : (k == 1) ? 9 : 3;
        f = '0;
        f[DW-1 -: 2] = 2'b10;
        f[`STREAM_ID_H:`STREAM_ID_L] = s[`STREAM_ID_H-`STREAM_ID_L:0];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input int k, input logic [PW-1:0] d,
                         input logic last);
        logic tail;
        if (inpkt[k] == 0) begin
            expq[k].push_back(head_of(k));
            mcnt[k]  = 1;
            inpkt[k] = 1;
        end
        tail = (mcnt[k] == pl_of(k) - 1) || last;
        expq[k].push_back({tail ? 2'b01 : 2'b00, d});
        if (tail) begin
            inpkt[k] = 0;
            mcnt[k]  = 0;
        end else begin
            mcnt[k]++;
        end
    endtask

    // Offer one beat; returns just after the edge that accepts it.
    task automatic send(input int k, input logic [PW-1:0] d,
                        input logic last, input int idle_max);
        int n;
        int t;
        bit ok;
        n = (idle_max > 0) ? int'($urandom_range(idle_max, 0)) : 0;
        repeat (n) begin
            @(negedge clk);
            pv[k] = 1'b0;
            if (rmode) rdy[k] = 1'($urandom_range(1, 0));
        end
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 300) begin
            @(negedge clk);
            pv[k]    = 1'b1;
            pd[k]    = d;
            plast[k] = last;
            if (rmode) rdy[k] = 1'($urandom_range(1, 0));
            #1;
            ok = pr[k];
            t++;
        end
        chk("send_accept", {31'd0, ok}, 32'd1);
        model(k, d, last);
        @(posedge clk);
    endtask

    task automatic stop(input int k);
        @(negedge clk);
        pv[k]    = 1'b0;
        plast[k] = 1'b0;
    endtask

    task automatic drain(input int k, input string tag);
        int t;
        int n;
        t = 0;
        n = expq[k].size() - eb[k];
        while (gotq[k].size() - gb[k] < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_count"}, gotq[k].size() - gb[k], n);
        for (int i = 0; i < n && gb[k] + i < gotq[k].size(); i++)
            chk($sformatf("%s_flit%0d", tag, i),
                gotq[k][gb[k] + i], expq[k][eb[k] + i]);
        gb[k] = gotq[k].size();
        eb[k] = expq[k].size();
    endtask

    initial begin
        int s;
        int exp_pc [5];
        exp_pc = '{1, 2, 3, 0, 1};
        rmode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rstn[k] = 1'b0; pv[k] = 1'b0; pd[k] = '0;
            plast[k] = 1'b0; rdy[k] = 1'b1;
            gb[k] = 0; eb[k] = 0; pb[k] = 0; inpkt[k] = 0; mcnt[k] = 0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid%0d", k), {31'd0, vo[k]}, 32'd0);
            chk($sformatf("rst_data%0d", k), dout[k], 32'd0);
            chk($sformatf("rst_pkt%0d", k), {16'd0, pc[k]}, 32'd0);
            chk($sformatf("rst_busy%0d", k), {31'd0, busy[k]}, 32'd0);
            rstn[k] = 1'b1;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) pb[k] = pcq[k].size();

        // pl=4, id 5: HEAD, 0xA, 0xB, TAIL 0xC back to back
        s = fcyc[0].size();
        send(0, 30'hA, 1'b0, 0);
        #1 chk("t1_busy_mid", {31'd0, busy[0]}, 32'd1);
        send(0, 30'hB, 1'b0, 0);
        send(0, 30'hC, 1'b0, 0);
        stop(0);
        drain(0, "t1");
        chk("t1_span", fcyc[0][s + 3] - fcyc[0][s], 32'd3);
        chk("t1_pkt", {16'd0, pc[0]}, 32'd1);
        chk("t1_busy_end", {31'd0, busy[0]}, 32'd0);

        // pl=16, 30 beats: two full packets with no output gaps
        s = fcyc[1].size();
        for (int i = 0; i < 30; i++) send(1, PW'(i + 1), 1'b0, 0);
        stop(1);
        drain(1, "t2");
        chk("t2_span", fcyc[1][s + 31] - fcyc[1][s], 32'd31);
        chk("t2_pkt", {16'd0, pc[1]}, 32'd2);

        // Early close on beat 4, then a full 16-flit packet
        for (int i = 0; i < 4; i++) send(1, PW'(8'h40 + i), i == 3, 0);
        for (int i = 0; i < 15; i++) send(1, PW'(8'h50 + i), 1'b0, 0);
        stop(1);
        drain(1, "t3");
        chk("t3_pkt", {16'd0, pc[1]}, 32'd4);

        // Backpressure: head parked, beat not taken
        @(negedge clk);
        rdy[1] = 1'b0; pv[1] = 1'b1; pd[1] = 30'h77; plast[1] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("bp_valid", {31'd0, vo[1]}, 32'd1);
        chk("bp_ready", {31'd0, pr[1]}, 32'd0);
        chk("bp_data", dout[1], head_of(1));
        pv[1] = 1'b0;
        rdy[1] = 1'b1;
        send(1, 30'h77, 1'b1, 0);
        stop(1);
        drain(1, "bp");
        chk("bp_pkt", {16'd0, pc[1]}, 32'd5);

        // Random ready and valid gaps, occasional early close
        rmode = 1'b1;
        for (int i = 0; i < 1000; i++)
            send(1, PW'($urandom), $urandom_range(15, 0) == 0, 2);
        stop(1);
        #1;
        rmode  = 1'b0;
        rdy[1] = 1'b1;
        drain(1, "rnd");
        chk("rnd_stable", unstable[1], 32'd0);

        // Reset mid-packet after the second body flit
        send(0, 30'h1, 1'b0, 0);
        send(0, 30'h2, 1'b0, 0);
        #2;
        rstn[0] = 1'b0;
        pv[0]   = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, vo[0]}, 32'd0);
        chk("mrst_pkt", {16'd0, pc[0]}, 32'd0);
        chk("mrst_busy", {31'd0, busy[0]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn[0] = 1'b1;
        gb[0] = gotq[0].size();
        eb[0] = expq[0].size();
        inpkt[0] = 0;
        mcnt[0]  = 0;
        send(0, 30'h3, 1'b0, 0);
        send(0, 30'h4, 1'b0, 0);
        send(0, 30'h5, 1'b0, 0);
        stop(0);
        drain(0, "mrst");
        chk("mrst_pkt_after", {16'd0, pc[0]}, 32'd1);

        // pl=2 with a 2-bit packet counter: HEAD/TAIL pairs, count wraps
        for (int i = 0; i < 5; i++) send(2, PW'(8'h10 + i), 1'b0, 0);
        stop(2);
        drain(2, "pl2");
        chk("pl2_npkt", pcq[2].size() - pb[2], 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("pl2_pkt%0d", i), {16'd0, pcq[2][pb[2] + i]},
                exp_pc[i]);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
